// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word-aligned requests to instruction memory, fills the F/D register.
// Latency: an ack in cycle t shows the word on InstrD from cycle t+1; 1 instr/cycle with zero-wait memory.
// Backpressure: StallD parks one acked word in a hold buffer and drops IMemReq until decode accepts it.
// Optional build macro FETCH_PERF_CNT_EN adds saturating FetchCount/BubbleCount counters (tied to 0 otherwise).
module fetch_unit #(
    parameter int              N      = 32,
    parameter logic [N-1:0]    RST_PC = {N{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          BranchTakenE,
    input  logic [N-1:0]  ALUResultE,
    input  logic          PCSrcW,
    input  logic [N-1:0]  ResultW,
    output logic          IMemReq,
    output logic [N-1:0]  IMemAddr,
    input  logic          IMemAck,
    input  logic [N-1:0]  IMemRdata,
    output logic [N-1:0]  InstrD,
    output logic [N-1:0]  PCPlus8D,
    output logic          ValidD,
    output logic [31:0]   FetchCount,
    output logic [31:0]   BubbleCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t       state;

    // pc is the next address to fetch; it differs from IMemAddr only in DROP,
    // where the stale request must stay on the bus until it is acked.
    logic [N-1:0] pc;
    logic [N-1:0] hold_instr;
    logic [N-1:0] hold_pc8;

    logic         redirect;
    logic [N-1:0] redir_src;
    logic [N-1:0] target;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_plus8;

    logic         fd_new_vld;
    logic [N-1:0] fd_new_instr;
    logic [N-1:0] fd_new_pc8;

    // Redirect selection and the candidate word for the F/D register this cycle.
    always_comb begin
        redirect     = PCSrcW | BranchTakenE;
        // Writeback is architecturally older than execute, so its $pc write wins.
        redir_src    = PCSrcW ? ResultW : ALUResultE;
        target       = redir_src & ~N'(3);
        pc_plus4     = pc + N'(4);
        pc_plus8     = pc + N'(8);

        fd_new_vld   = 1'b0;
        fd_new_instr = hold_instr;
        fd_new_pc8   = hold_pc8;
        if ((state == REQ) && IMemAck && !redirect && !StallD) begin
            fd_new_vld   = 1'b1;
            fd_new_instr = IMemRdata;
            fd_new_pc8   = pc_plus8;
        end else if ((state == HOLD) && !redirect && !StallD) begin
            fd_new_vld   = 1'b1;
        end
    end

    // Fetch FSM: PC, memory request registers and the one-entry hold buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RST_PC;
            IMemReq    <= 1'b0;
            IMemAddr   <= '0;
            hold_instr <= '0;
            hold_pc8   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= REQ;
                    IMemReq <= 1'b1;
                    if (redirect) begin
                        pc       <= target;
                        IMemAddr <= target;
                    end else begin
                        IMemAddr <= pc;
                    end
                end

                REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (IMemAck) begin
                            // Wrong-path word arrives with the redirect: drop it, fetch target now.
                            IMemAddr <= target;
                        end else begin
                            // Request already on the bus cannot be withdrawn; wait out its ack.
                            state <= DROP;
                        end
                    end else if (IMemAck) begin
                        pc       <= pc_plus4;
                        IMemAddr <= pc_plus4;
                        if (StallD) begin
                            hold_instr <= IMemRdata;
                            hold_pc8   <= pc_plus8;
                            IMemReq    <= 1'b0;
                            state      <= HOLD;
                        end
                    end
                end

                DROP: begin
                    if (IMemAck) begin
                        state <= REQ;
                        if (redirect) begin
                            pc       <= target;
                            IMemAddr <= target;
                        end else begin
                            IMemAddr <= pc;
                        end
                    end else if (redirect) begin
                        pc <= target;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        // Buffered word is younger than the redirecting instruction: discard.
                        pc       <= target;
                        IMemAddr <= target;
                        IMemReq  <= 1'b1;
                        state    <= REQ;
                    end else if (!StallD) begin
                        // IMemAddr already holds pc from the ack that filled the buffer.
                        IMemReq <= 1'b1;
                        state   <= REQ;
                    end
                end

                default: begin
                    state   <= IDLE;
                    IMemReq <= 1'b0;
                end
            endcase
        end
    end

    // F/D pipeline register: flush beats stall beats new word beats bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            InstrD   <= '0;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (fd_new_vld) begin
                InstrD   <= fd_new_instr;
                PCPlus8D <= fd_new_pc8;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= '0;
                PCPlus8D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;

    // Saturating performance counters: valid F/D loads and bubble cycles out of reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!FlushD && !StallD && fd_new_vld && (fetch_cnt != 32'hFFFF_FFFF)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!ValidD && (bubble_cnt != 32'hFFFF_FFFF)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt;
    assign BubbleCount = bubble_cnt;
`else
    assign FetchCount  = 32'd0;
    assign BubbleCount = 32'd0;
`endif

    // Request address must always be word aligned.
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        IMemReq |-> (IMemAddr[1:0] == 2'b00));

    // An unacked request keeps its address on the bus.
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (IMemReq && !IMemAck) |=> (IMemReq && (IMemAddr == $past(IMemAddr))));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenE;
    logic [31:0] ALUResultE;
    logic        PCSrcW;
    logic [31:0] ResultW;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(.N(32), .RST_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemRdata(IMemRdata),
        .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
        .FetchCount(FetchCount), .BubbleCount(BubbleCount)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        StallD = 1'b0; FlushD = 1'b0; BranchTakenE = 1'b0; ALUResultE = '0;
        PCSrcW = 1'b0; ResultW = '0; IMemAck = 1'b0; IMemRdata = '0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", ValidD); end
        n_cmp++; if (InstrD !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h exp 0", InstrD); end
        n_cmp++; if (PCPlus8D !== 32'h0) begin n_err++; $display("FAIL rst_pc8 got %h exp 0", PCPlus8D); end
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", IMemReq); end
        n_cmp++; if (IMemAddr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", IMemAddr); end
        n_cmp++; if (FetchCount !== 32'h0) begin n_err++; $display("FAIL rst_fcnt got %0d exp 0", FetchCount); end
        n_cmp++; if (BubbleCount !== 32'h0) begin n_err++; $display("FAIL rst_bcnt got %0d exp 0", BubbleCount); end
        rst = 1'b1;
        tick();
        n_cmp++; if (IMemReq !== 1'b1) begin n_err++; $display("FAIL first_req got %b exp 1", IMemReq); end
        n_cmp++; if (IMemAddr !== 32'h0) begin n_err++; $display("FAIL first_addr got %h exp 0", IMemAddr); end
    endtask

    task automatic test_zero_wait;
        logic [31:0] exp_f;
        logic [31:0] exp_b;
        do_reset();
        tick();
        for (int k = 0; k < 6; k++) begin
            IMemAck   = 1'b1;
            IMemRdata = 32'(k * 4) ^ PAT;
            tick();
            n_cmp++; if (InstrD !== (32'(k * 4) ^ PAT)) begin n_err++; $display("FAIL zw_instr[%0d] got %h exp %h", k, InstrD, 32'(k * 4) ^ PAT); end
            n_cmp++; if (PCPlus8D !== 32'(k * 4 + 8)) begin n_err++; $display("FAIL zw_pc8[%0d] got %h exp %h", k, PCPlus8D, 32'(k * 4 + 8)); end
            n_cmp++; if (ValidD !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d] got %b exp 1", k, ValidD); end
            n_cmp++; if (IMemAddr !== 32'(k * 4 + 4)) begin n_err++; $display("FAIL zw_addr[%0d] got %h exp %h", k, IMemAddr, 32'(k * 4 + 4)); end
        end
        IMemAck = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        exp_f = 32'd6; exp_b = 32'd2;
`else
        exp_f = 32'd0; exp_b = 32'd0;
`endif
        n_cmp++; if (FetchCount !== exp_f) begin n_err++; $display("FAIL zw_fcnt got %0d exp %0d", FetchCount, exp_f); end
        n_cmp++; if (BubbleCount !== exp_b) begin n_err++; $display("FAIL zw_bcnt got %0d exp %0d", BubbleCount, exp_b); end
    endtask

    task automatic test_wait_states;
        logic [31:0] exp_f;
        logic [31:0] exp_b;
        do_reset();
        tick();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'(w * 4)) begin n_err++; $display("FAIL ws_addr[%0d.%0d] got %b/%h exp 1/%h", w, c, IMemReq, IMemAddr, 32'(w * 4)); end
                IMemAck   = (c == 2);
                IMemRdata = 32'(w * 4) ^ PAT;
                tick();
                IMemAck   = 1'b0;
                n_cmp++; if (ValidD !== (c == 2)) begin n_err++; $display("FAIL ws_valid[%0d.%0d] got %b exp %b", w, c, ValidD, (c == 2)); end
                if (c == 2) begin
                    n_cmp++; if (InstrD !== (32'(w * 4) ^ PAT)) begin n_err++; $display("FAIL ws_instr[%0d] got %h exp %h", w, InstrD, 32'(w * 4) ^ PAT); end
                end
            end
        end
`ifdef FETCH_PERF_CNT_EN
        exp_f = 32'd3; exp_b = 32'd8;
`else
        exp_f = 32'd0; exp_b = 32'd0;
`endif
        n_cmp++; if (FetchCount !== exp_f) begin n_err++; $display("FAIL ws_fcnt got %0d exp %0d", FetchCount, exp_f); end
        n_cmp++; if (BubbleCount !== exp_b) begin n_err++; $display("FAIL ws_bcnt got %0d exp %0d", BubbleCount, exp_b); end
    endtask

    task automatic test_stall_hold;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            IMemAck   = 1'b1;
            IMemRdata = 32'(k * 4) ^ PAT;
            tick();
        end
        n_cmp++; if (IMemAddr !== 32'h10) begin n_err++; $display("FAIL st_pre_addr got %h exp 10", IMemAddr); end
        IMemAck = 1'b1; IMemRdata = 32'h10 ^ PAT; StallD = 1'b1;
        tick();
        IMemAck = 1'b0;
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL st_req0 got %b exp 0", IMemReq); end
        n_cmp++; if (InstrD !== (32'hC ^ PAT) || ValidD !== 1'b1) begin n_err++; $display("FAIL st_keep got %h/%b exp %h/1", InstrD, ValidD, 32'hC ^ PAT); end
        tick();
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL st_req1 got %b exp 0", IMemReq); end
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0) begin n_err++; $display("FAIL st_flush got %b/%h/%h exp 0/0/0", ValidD, InstrD, PCPlus8D); end
        n_cmp++; if (IMemReq !== 1'b0) begin n_err++; $display("FAIL st_req2 got %b exp 0", IMemReq); end
        tick();
        n_cmp++; if (IMemReq !== 1'b0 || ValidD !== 1'b0) begin n_err++; $display("FAIL st_req3 got %b/%b exp 0/0", IMemReq, ValidD); end
        StallD = 1'b0;
        tick();
        n_cmp++; if (InstrD !== (32'h10 ^ PAT)) begin n_err++; $display("FAIL st_instr got %h exp %h", InstrD, 32'h10 ^ PAT); end
        n_cmp++; if (PCPlus8D !== 32'h18 || ValidD !== 1'b1) begin n_err++; $display("FAIL st_pc8 got %h/%b exp 18/1", PCPlus8D, ValidD); end
        n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h14) begin n_err++; $display("FAIL st_next got %b/%h exp 1/14", IMemReq, IMemAddr); end
    endtask

    task automatic test_branch_drop;
        do_reset();
        tick();
        for (int k = 0; k < 8; k++) begin
            IMemAck   = 1'b1;
            IMemRdata = 32'(k * 4) ^ PAT;
            tick();
        end
        IMemAck = 1'b0; BranchTakenE = 1'b1; ALUResultE = 32'h103;
        tick();
        BranchTakenE = 1'b0;
        n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h20) begin n_err++; $display("FAIL br_drop got %b/%h exp 1/20", IMemReq, IMemAddr); end
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL br_bubble got %b exp 0", ValidD); end
        tick();
        n_cmp++; if (IMemAddr !== 32'h20) begin n_err++; $display("FAIL br_hold_addr got %h exp 20", IMemAddr); end
        IMemAck = 1'b1; IMemRdata = 32'h20 ^ PAT;
        tick();
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h0) begin n_err++; $display("FAIL br_stale got %b/%h exp 0/0", ValidD, InstrD); end
        n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin n_err++; $display("FAIL br_target got %b/%h exp 1/100", IMemReq, IMemAddr); end
        IMemRdata = 32'h100 ^ PAT;
        tick();
        IMemAck = 1'b0;
        n_cmp++; if (InstrD !== (32'h100 ^ PAT) || PCPlus8D !== 32'h108 || ValidD !== 1'b1) begin n_err++; $display("FAIL br_first got %h/%h/%b exp %h/108/1", InstrD, PCPlus8D, ValidD, 32'h100 ^ PAT); end
        n_cmp++; if (IMemAddr !== 32'h104) begin n_err++; $display("FAIL br_next got %h exp 104", IMemAddr); end
    endtask

    task automatic test_redirect_priority;
        do_reset();
        tick();
        PCSrcW = 1'b1; ResultW = 32'h200; BranchTakenE = 1'b1; ALUResultE = 32'h300;
        IMemAck = 1'b1; IMemRdata = PAT;
        tick();
        n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h200) begin n_err++; $display("FAIL pr_addr got %b/%h exp 1/200", IMemReq, IMemAddr); end
        n_cmp++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL pr_discard got %b exp 0", ValidD); end
        IMemAck = 1'b0; BranchTakenE = 1'b0; ResultW = 32'h43;
        tick();
        n_cmp++; if (IMemAddr !== 32'h200) begin n_err++; $display("FAIL pr_drop got %h exp 200", IMemAddr); end
        PCSrcW = 1'b0; BranchTakenE = 1'b1; ALUResultE = 32'h302;
        tick();
        BranchTakenE = 1'b0;
        n_cmp++; if (IMemAddr !== 32'h200) begin n_err++; $display("FAIL pr_drop2 got %h exp 200", IMemAddr); end
        IMemAck = 1'b1; IMemRdata = 32'h200 ^ PAT;
        tick();
        IMemAck = 1'b0;
        n_cmp++; if (IMemAddr !== 32'h300 || ValidD !== 1'b0) begin n_err++; $display("FAIL pr_overwrite got %h/%b exp 300/0", IMemAddr, ValidD); end
    endtask

    task automatic test_wrap_and_reset;
        do_reset();
        BranchTakenE = 1'b1; ALUResultE = 32'hFFFF_FFFF;
        tick();
        BranchTakenE = 1'b0;
        n_cmp++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_idle_redir got %b/%h exp 1/fffffffc", IMemReq, IMemAddr); end
        IMemAck = 1'b1; IMemRdata = 32'h5A5A_5A59;
        tick();
        n_cmp++; if (InstrD !== 32'h5A5A_5A59 || ValidD !== 1'b1) begin n_err++; $display("FAIL wr_instr got %h/%b exp 5a5a5a59/1", InstrD, ValidD); end
        n_cmp++; if (PCPlus8D !== 32'h4) begin n_err++; $display("FAIL wr_pc8 got %h exp 4", PCPlus8D); end
        n_cmp++; if (IMemAddr !== 32'h0) begin n_err++; $display("FAIL wr_addr got %h exp 0", IMemAddr); end
        rst = 1'b0; IMemRdata = PAT;
        tick();
        n_cmp++; if (IMemReq !== 1'b0 || IMemAddr !== 32'h0 || ValidD !== 1'b0 || InstrD !== 32'h0) begin n_err++; $display("FAIL wr_midrst got %b/%h/%b/%h exp 0/0/0/0", IMemReq, IMemAddr, ValidD, InstrD); end
        rst = 1'b1; IMemAck = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_branch_drop();
        test_redirect_priority();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
